// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch port
//   (read-only) and the MEM-stage data port (load/store). Each access holds
//   the memory command for MEM_LAT cycles, samples read data on the last
//   of them, then pulses the owner's grant for one cycle. When both ports
//   request in IDLE, the port that was not served last wins.
//
// Ports
//   i_clk, i_reset           clock (rising edge), async active-high reset
//   i_ifReq/i_ifAddr         fetch request, held until o_ifGnt
//   o_ifGnt/o_ifData         fetch-complete pulse, registered fetched word
//   i_dReq/i_dWe/i_dAddr/
//   i_dWrData                data request (1=store), held until o_dGnt
//   o_dGnt/o_dRdData         data-complete pulse, registered load word
//   o_stall                  some request is pending and not granted now
//   o_memAddr/o_memWrData    latched memory address / write data
//   o_memCtrl                [1]=read, [0]=write, 00 outside ACCESS
//   i_memRdData              memory read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ifReq,
   input  logic [ADDR_W-1:0] i_ifAddr,
   output logic              o_ifGnt,
   output logic [DATA_W-1:0] o_ifData,
   input  logic              i_dReq,
   input  logic              i_dWe,
   input  logic [ADDR_W-1:0] i_dAddr,
   input  logic [DATA_W-1:0] i_dWrData,
   output logic              o_dGnt,
   output logic [DATA_W-1:0] o_dRdData,
   output logic              o_stall,
   output logic [ADDR_W-1:0] o_memAddr,
   output logic [DATA_W-1:0] o_memWrData,
   output logic [1:0]        o_memCtrl,
   input  logic [DATA_W-1:0] i_memRdData
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wrdata_q, wrdata_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] d_data_q, d_data_d;
   logic              d_wins;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the values that existed before the edge, independent of statement order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_IF;
         last_q    <= OWN_IF;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wrdata_q  <= '0;
         if_data_q <= '0;
         d_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wrdata_q  <= wrdata_d;
         if_data_q <= if_data_d;
         d_data_q  <= d_data_d;
      end
   end

   // Data port wins when it is the only requester, or when both request and
   // the fetch port was served last.
   assign d_wins = i_dReq & (~i_ifReq | (last_q == OWN_IF));

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wrdata_d  = wrdata_q;
      if_data_d = if_data_q;
      d_data_d  = d_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_ifReq || i_dReq) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
               if (d_wins) begin
                  owner_d  = OWN_D;
                  addr_d   = i_dAddr;
                  we_d     = i_dWe;
                  wrdata_d = i_dWrData;
               end else begin
                  owner_d  = OWN_IF;
                  addr_d   = i_ifAddr;
                  we_d     = 1'b0;
               end
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               if (owner_q == OWN_IF) begin
                  if_data_d = i_memRdData;
               end else if (!we_q) begin
                  d_data_d = i_memRdData;
               end
            end
         end
         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant and command decode straight from state so async reset clears them
   // in the cycle it asserts.
   assign o_ifGnt   = (state_q == S_RESP) && (owner_q == OWN_IF);
   assign o_dGnt    = (state_q == S_RESP) && (owner_q == OWN_D);
   assign o_memCtrl = (state_q != S_ACCESS) ? 2'b00 :
                      ((owner_q == OWN_D) && we_q) ? 2'b01 : 2'b10;

   assign o_stall     = (i_ifReq & ~o_ifGnt) | (i_dReq & ~o_dGnt);
   assign o_memAddr   = addr_q;
   assign o_memWrData = wrdata_q;
   assign o_ifData    = if_data_q;
   assign o_dRdData   = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_memRdData = '0;

   // Main DUT, MEM_LAT = 2
   logic        i_ifReq = 1'b0, i_dReq = 1'b0, i_dWe = 1'b0;
   logic [31:0] i_ifAddr = '0, i_dAddr = '0, i_dWrData = '0;
   logic        o_ifGnt, o_dGnt, o_stall;
   logic [31:0] o_ifData, o_dRdData, o_memAddr, o_memWrData;
   logic [1:0]  o_memCtrl;

   // Second DUT, MEM_LAT = 1
   logic        l_ifReq = 1'b0, l_dReq = 1'b0, l_dWe = 1'b0;
   logic [31:0] l_ifAddr = '0, l_dAddr = '0, l_dWrData = '0;
   logic        l_ifGnt, l_dGnt, l_stall;
   logic [31:0] l_ifData, l_dRdData, l_memAddr, l_memWrData;
   logic [1:0]  l_memCtrl;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr), .o_ifGnt(o_ifGnt), .o_ifData(o_ifData),
      .i_dReq(i_dReq), .i_dWe(i_dWe), .i_dAddr(i_dAddr), .i_dWrData(i_dWrData),
      .o_dGnt(o_dGnt), .o_dRdData(o_dRdData), .o_stall(o_stall),
      .o_memAddr(o_memAddr), .o_memWrData(o_memWrData), .o_memCtrl(o_memCtrl),
      .i_memRdData(i_memRdData)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_ifReq(l_ifReq), .i_ifAddr(l_ifAddr), .o_ifGnt(l_ifGnt), .o_ifData(l_ifData),
      .i_dReq(l_dReq), .i_dWe(l_dWe), .i_dAddr(l_dAddr), .i_dWrData(l_dWrData),
      .o_dGnt(l_dGnt), .o_dRdData(l_dRdData), .o_stall(l_stall),
      .o_memAddr(l_memAddr), .o_memWrData(l_memWrData), .o_memCtrl(l_memCtrl),
      .i_memRdData(i_memRdData)
   );

   // Move to the next cycle: 2 time units after the rising edge.
   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   // Leaves the bench in the first cycle whose closing edge sees reset low.
   task automatic do_reset();
      i_reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #2;
      i_reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (o_memCtrl !== 2'b00) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00", o_memCtrl); end
      n_cmp++; if ({o_ifGnt, o_dGnt, o_stall} !== 3'b000) begin n_bad++; $display("FAIL reset_gnt_stall: got %b want 000", {o_ifGnt, o_dGnt, o_stall}); end
      n_cmp++; if (o_memAddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", o_memAddr); end
      n_cmp++; if (o_ifData !== 32'h0 || o_dRdData !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h/%h want 0/0", o_ifData, o_dRdData); end
   endtask

   task automatic test_fetch();
      // cycle t
      i_memRdData = 32'hDEADBEEF;
      i_ifAddr = 32'h100;
      i_ifReq = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_cmp++; if (o_memCtrl !== 2'b10) begin n_bad++; $display("FAIL fetch_ctrl_t%0d: got %b want 10", k, o_memCtrl); end
         n_cmp++; if (o_memAddr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr_t%0d: got %h want 100", k, o_memAddr); end
         n_cmp++; if (o_ifGnt !== 1'b0) begin n_bad++; $display("FAIL fetch_early_gnt_t%0d: got %b want 0", k, o_ifGnt); end
      end
      step(); // t+3
      n_cmp++; if (o_ifGnt !== 1'b1) begin n_bad++; $display("FAIL fetch_gnt: got %b want 1", o_ifGnt); end
      n_cmp++; if (o_ifData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_data: got %h want deadbeef", o_ifData); end
      n_cmp++; if (o_memCtrl !== 2'b00) begin n_bad++; $display("FAIL fetch_ctrl_resp: got %b want 00", o_memCtrl); end
      i_ifReq = 1'b0;
      step(); // t+4
      n_cmp++; if (o_ifGnt !== 1'b0) begin n_bad++; $display("FAIL fetch_gnt_pulse: got %b want 0", o_ifGnt); end
   endtask

   task automatic test_load_stall();
      // cycle t
      i_memRdData = 32'hCAFEF00D;
      i_dAddr = 32'h80;
      i_dWe = 1'b0;
      i_dReq = 1'b1;
      #1;
      n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL load_stall_t0: got %b want 1", o_stall); end
      for (int k = 1; k <= 2; k++) begin
         step();
         n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL load_stall_t%0d: got %b want 1", k, o_stall); end
         n_cmp++; if (o_memCtrl !== 2'b10) begin n_bad++; $display("FAIL load_ctrl_t%0d: got %b want 10", k, o_memCtrl); end
      end
      step(); // t+3
      n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL load_stall_t3: got %b want 0", o_stall); end
      n_cmp++; if (o_dGnt !== 1'b1) begin n_bad++; $display("FAIL load_gnt: got %b want 1", o_dGnt); end
      n_cmp++; if (o_dRdData !== 32'hCAFEF00D) begin n_bad++; $display("FAIL load_data: got %h want cafef00d", o_dRdData); end
      n_cmp++; if (o_ifData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_ifdata_hold: got %h want deadbeef", o_ifData); end
      i_dReq = 1'b0;
      step();
      n_cmp++; if (o_stall !== 1'b0 || o_dGnt !== 1'b0) begin n_bad++; $display("FAIL idle_stall_gnt: got %b%b want 00", o_stall, o_dGnt); end
      step();
      n_cmp++; if (o_memCtrl !== 2'b00) begin n_bad++; $display("FAIL idle_ctrl: got %b want 00", o_memCtrl); end
   endtask

   task automatic test_store();
      // cycle t; memory drives a value that must not reach o_dRdData
      i_memRdData = 32'h55555555;
      i_dAddr = 32'h40;
      i_dWrData = 32'h12345678;
      i_dWe = 1'b1;
      i_dReq = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_cmp++; if (o_memCtrl !== 2'b01) begin n_bad++; $display("FAIL store_ctrl_t%0d: got %b want 01", k, o_memCtrl); end
         n_cmp++; if (o_memWrData !== 32'h12345678 || o_memAddr !== 32'h40) begin n_bad++; $display("FAIL store_bus_t%0d: got %h@%h want 12345678@40", k, o_memWrData, o_memAddr); end
      end
      step(); // t+3
      n_cmp++; if (o_dGnt !== 1'b1 || o_ifGnt !== 1'b0) begin n_bad++; $display("FAIL store_gnt: got d=%b if=%b want d=1 if=0", o_dGnt, o_ifGnt); end
      n_cmp++; if (o_dRdData !== 32'hCAFEF00D) begin n_bad++; $display("FAIL store_rddata_hold: got %h want cafef00d", o_dRdData); end
      i_dReq = 1'b0;
      i_dWe = 1'b0;
      step();
      n_cmp++; if (o_memWrData !== 32'h12345678) begin n_bad++; $display("FAIL store_wrdata_hold: got %h want 12345678", o_memWrData); end
   endtask

   task automatic test_contention();
      do_reset(); // last owner back to fetch, so data wins first
      i_memRdData = 32'h11112222;
      i_ifAddr = 32'h200;
      i_dAddr = 32'h300;
      i_dWe = 1'b0;
      i_ifReq = 1'b1;
      i_dReq = 1'b1;
      step(); // t+1
      n_cmp++; if (o_memAddr !== 32'h300) begin n_bad++; $display("FAIL cont_first_addr: got %h want 300", o_memAddr); end
      step(); step(); // t+3
      n_cmp++; if (o_dGnt !== 1'b1 || o_ifGnt !== 1'b0) begin n_bad++; $display("FAIL cont_gnt_d1: got d=%b if=%b want d=1 if=0", o_dGnt, o_ifGnt); end
      n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL cont_stall_t3: got %b want 1", o_stall); end
      // data port keeps requesting: fetch must win the next round
      step(); // t+4
      n_cmp++; if (o_memCtrl !== 2'b00) begin n_bad++; $display("FAIL cont_idle_ctrl: got %b want 00", o_memCtrl); end
      step(); // t+5
      n_cmp++; if (o_memAddr !== 32'h200 || o_memCtrl !== 2'b10) begin n_bad++; $display("FAIL cont_if_access_t5: got %h/%b want 200/10", o_memAddr, o_memCtrl); end
      step(); // t+6
      n_cmp++; if (o_memCtrl !== 2'b10) begin n_bad++; $display("FAIL cont_if_access_t6: got %b want 10", o_memCtrl); end
      step(); // t+7
      n_cmp++; if (o_ifGnt !== 1'b1 || o_dGnt !== 1'b0) begin n_bad++; $display("FAIL cont_gnt_if: got if=%b d=%b want if=1 d=0", o_ifGnt, o_dGnt); end
      n_cmp++; if (o_ifData !== 32'h11112222) begin n_bad++; $display("FAIL cont_if_data: got %h want 11112222", o_ifData); end
      step(); step(); // t+9: data port again
      n_cmp++; if (o_memAddr !== 32'h300) begin n_bad++; $display("FAIL cont_third_addr: got %h want 300", o_memAddr); end
      step(); step(); // t+11
      n_cmp++; if (o_dGnt !== 1'b1 || o_ifGnt !== 1'b0) begin n_bad++; $display("FAIL cont_gnt_d2: got d=%b if=%b want d=1 if=0", o_dGnt, o_ifGnt); end
      i_ifReq = 1'b0;
      i_dReq = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_access();
      i_memRdData = 32'h77778888;
      i_dAddr = 32'h44;
      i_dWe = 1'b0;
      i_dReq = 1'b1;
      step(); // t+1: ACCESS
      n_cmp++; if (o_memCtrl !== 2'b10) begin n_bad++; $display("FAIL rst_mid_pre_ctrl: got %b want 10", o_memCtrl); end
      i_reset = 1'b1;
      #1;
      n_cmp++; if (o_memCtrl !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ctrl_drop: got %b want 00", o_memCtrl); end
      step(); // t+2, reset still high
      n_cmp++; if (o_dGnt !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_gnt: got %b want 0", o_dGnt); end
      i_reset = 1'b0; // next edge is the release-edge sample
      #1;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_cmp++; if (o_memCtrl !== 2'b10 || o_dGnt !== 1'b0) begin n_bad++; $display("FAIL rst_reissue_u%0d: got ctrl=%b gnt=%b want ctrl=10 gnt=0", k, o_memCtrl, o_dGnt); end
      end
      step(); // u+3
      n_cmp++; if (o_dGnt !== 1'b1) begin n_bad++; $display("FAIL rst_reissue_gnt: got %b want 1", o_dGnt); end
      n_cmp++; if (o_dRdData !== 32'h77778888) begin n_bad++; $display("FAIL rst_reissue_data: got %h want 77778888", o_dRdData); end
      i_dReq = 1'b0;
      step();
   endtask

   task automatic test_lat1();
      i_memRdData = 32'hA5A5A5A5;
      l_ifAddr = 32'h20;
      l_ifReq = 1'b1;
      step(); // t+1
      n_cmp++; if (l_memCtrl !== 2'b10 || l_memAddr !== 32'h20) begin n_bad++; $display("FAIL lat1_access: got %b/%h want 10/20", l_memCtrl, l_memAddr); end
      n_cmp++; if (l_ifGnt !== 1'b0) begin n_bad++; $display("FAIL lat1_early_gnt: got %b want 0", l_ifGnt); end
      step(); // t+2
      n_cmp++; if (l_memCtrl !== 2'b00) begin n_bad++; $display("FAIL lat1_ctrl_t2: got %b want 00", l_memCtrl); end
      n_cmp++; if (l_ifGnt !== 1'b1 || l_ifData !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL lat1_gnt: got %b/%h want 1/a5a5a5a5", l_ifGnt, l_ifData); end
      l_ifReq = 1'b0;
      step();
      n_cmp++; if (l_ifGnt !== 1'b0) begin n_bad++; $display("FAIL lat1_gnt_pulse: got %b want 0", l_ifGnt); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_stall();
      test_store();
      test_contention();
      test_reset_mid_access();
      test_lat1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
